// File: rtl/gonso_wb_pkg.sv
// Shared types and constants for the Gonso Wishbone initiator.
package gonso_wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    localparam logic [31:0] GONSO_ADDR       = 32'h3003_0004;
    localparam logic [31:0] GONSO_PLUS_ADDR  = 32'h3003_0008;
    localparam logic [31:0] GONSO_COLOR_ADDR = 32'h3003_000C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wbm_state_e;

endpackage

// File: rtl/gonso_wbm_watchdog.sv
// Ack-wait counter for gonso_wb_master; only used when GONSO_WBM_TIMEOUT_EN is defined.
module gonso_wbm_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;

    // Count waiting cycles; saturate at the terminal value until cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (count_en && !expired) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == TERMINAL);

endmodule

// File: rtl/gonso_wb_master.sv
// Wishbone classic single-transfer initiator with valid/ready command and response ports.
// Optional ack timeout enabled by defining GONSO_WBM_TIMEOUT_EN.
module gonso_wb_master
    import gonso_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [31:0]          cmd_addr,
    input  logic [WB_DATA_W-1:0] cmd_wdata,
    input  logic [WB_SEL_W-1:0]  cmd_sel,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WB_DATA_W-1:0] rsp_rdata,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [31:0]          wbm_adr_o,
    output logic [WB_DATA_W-1:0] wbm_dat_o,
    output logic [WB_SEL_W-1:0]  wbm_sel_o,
    input  logic [WB_DATA_W-1:0] wbm_dat_i,
    input  logic                 wbm_ack_i
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] BUS  = ST_BUS;
    localparam logic [1:0] RESP = ST_RESP;

    logic [1:0]           state_r;
    logic [1:0]           state_s;
    logic [WB_DATA_W-1:0] rdata_s;
    logic                 timeout_s;
    logic                 cmd_fire_s;
    logic                 expired_s;

    assign cmd_fire_s = cmd_valid && cmd_ready;

`ifdef GONSO_WBM_TIMEOUT_EN
    logic wd_count_en_s;

    assign wd_count_en_s = (state_r == BUS) && !wbm_ack_i;

    gonso_wbm_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (cmd_fire_s),
        .count_en (wd_count_en_s),
        .expired  (expired_s)
    );
`else
    assign expired_s = 1'b0;
`endif

    // Next-state and response capture; ack takes priority over the terminal count.
    always_comb begin
        state_s   = state_r;
        rdata_s   = rsp_rdata;
        timeout_s = rsp_timeout;
        case (state_r)
            IDLE: begin
                if (cmd_fire_s) begin
                    state_s = BUS;
                end else begin
                    state_s = IDLE;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    state_s   = RESP;
                    rdata_s   = wbm_we_o ? {WB_DATA_W{1'b0}} : wbm_dat_i;
                    timeout_s = 1'b0;
                end else if (expired_s && (TIMEOUT_CYCLES >= 2)) begin
                    state_s   = RESP;
                    rdata_s   = {WB_DATA_W{1'b0}};
                    timeout_s = 1'b1;
                end else begin
                    state_s = BUS;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and all outputs are registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cmd_ready   <= 1'b0;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= {WB_DATA_W{1'b0}};
            rsp_timeout <= 1'b0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_adr_o   <= 32'h0000_0000;
            wbm_dat_o   <= {WB_DATA_W{1'b0}};
            wbm_sel_o   <= {WB_SEL_W{1'b0}};
        end else begin
            state_r     <= state_s;
            cmd_ready   <= (state_s == IDLE);
            busy        <= (state_s != IDLE);
            rsp_valid   <= (state_s == RESP);
            rsp_rdata   <= rdata_s;
            rsp_timeout <= timeout_s;
            wbm_cyc_o   <= (state_s == BUS);
            wbm_stb_o   <= (state_s == BUS);
            if (cmd_fire_s) begin
                wbm_we_o  <= cmd_we;
                wbm_adr_o <= cmd_addr;
                wbm_dat_o <= cmd_wdata;
                wbm_sel_o <= cmd_sel;
            end else begin
                wbm_we_o  <= wbm_we_o;
                wbm_adr_o <= wbm_adr_o;
                wbm_dat_o <= wbm_dat_o;
                wbm_sel_o <= wbm_sel_o;
            end
        end
    end

endmodule

// File: tb/tb_gonso_wb_master.sv
// Directed self-checking bench for gonso_wb_master; timeout scenarios need GONSO_WBM_TIMEOUT_EN.
module tb_gonso_wb_master;
    import gonso_wb_pkg::*;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        busy;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    int checks = 0;
    int fails  = 0;
    logic [31:0] mem [4];

    gonso_wb_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1, "bench did not terminate");
    end

    // One transfer: responder acks in bus cycle ack_cycle (0 = never), response held for rsp_wait cycles.
    task automatic do_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] sel, input int ack_cycle, input int rsp_wait,
                           input logic stray, output int cyc_n, output logic stable_ok,
                           output logic [31:0] rdata, output logic tmo,
                           output logic hold_ok, output logic done_ok);
        int guard;
        guard = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL cmd_ready_wait: cmd_ready=%b, required 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_sel = sel;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_sel = 4'h0;
        cyc_n = 0;
        stable_ok = 1'b1;
        while (wbm_cyc_o === 1'b1 && cyc_n < 100) begin
            cyc_n++;
            if (wbm_stb_o !== 1'b1 || wbm_we_o !== we || wbm_adr_o !== addr ||
                wbm_dat_o !== wdata || wbm_sel_o !== sel || busy !== 1'b1 ||
                cmd_ready !== 1'b0 || rsp_valid !== 1'b0)
                stable_ok = 1'b0;
            if (cyc_n == ack_cycle) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = we ? 32'hDEAD_BEEF : mem[addr[3:2]];
                if (we) mem[addr[3:2]] = wbm_dat_o;
            end else begin
                wbm_ack_i = 1'b0;
            end
            @(negedge clk);
        end
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0BAD_0BAD;
        rdata   = rsp_rdata;
        tmo     = rsp_timeout;
        hold_ok = (rsp_valid === 1'b1) && (wbm_stb_o === 1'b0);
        for (int i = 0; i < rsp_wait; i++) begin
            if (stray && i == 0) wbm_ack_i = 1'b1;
            @(negedge clk);
            wbm_ack_i = 1'b0;
            if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_timeout !== tmo ||
                cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0)
                hold_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        done_ok = (rsp_valid === 1'b0) && (cmd_ready === 1'b1) && (busy === 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL rst_cmd_ready: got %b, required 0", cmd_ready); end
        checks++; if ({rsp_valid, rsp_timeout, busy, wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 6'b0) begin
            fails++; $display("FAIL rst_ctrl: got %b, required 000000", {rsp_valid, rsp_timeout, busy, wbm_cyc_o, wbm_stb_o, wbm_we_o}); end
        checks++; if ({wbm_adr_o, wbm_dat_o, rsp_rdata, wbm_sel_o} !== 100'h0) begin
            fails++; $display("FAIL rst_data: adr=%h dat=%h rdata=%h sel=%h, required all 0", wbm_adr_o, wbm_dat_o, rsp_rdata, wbm_sel_o); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL rst_release: cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy); end
    endtask

    task automatic test_write;
        int n; logic st, tmo, hold, done; logic [31:0] rd;
        do_xfer(1'b1, GONSO_ADDR, 32'h1234_5678, 4'hF, 2, 0, 1'b0, n, st, rd, tmo, hold, done);
        checks++; if (n !== 2) begin fails++; $display("FAIL wr_stb_len: got %0d, required 2", n); end
        checks++; if (st !== 1'b1) begin fails++; $display("FAIL wr_bus_stable: got %b, required 1", st); end
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL wr_rdata: got %h, required 00000000", rd); end
        checks++; if (tmo !== 1'b0) begin fails++; $display("FAIL wr_timeout: got %b, required 0", tmo); end
        checks++; if (hold !== 1'b1) begin fails++; $display("FAIL wr_rsp_valid: got %b, required 1", hold); end
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL wr_rsp_done: got %b, required 1", done); end
    endtask

    task automatic test_read;
        int n; logic st, tmo, hold, done; logic [31:0] rd;
        do_xfer(1'b0, GONSO_ADDR, 32'h0, 4'hF, 2, 0, 1'b0, n, st, rd, tmo, hold, done);
        checks++; if (rd !== 32'h1234_5678) begin fails++; $display("FAIL rd_rdata: got %h, required 12345678", rd); end
        checks++; if (n !== 2 || st !== 1'b1) begin fails++; $display("FAIL rd_bus: len=%0d stable=%b, required 2 1", n, st); end
        checks++; if (tmo !== 1'b0 || done !== 1'b1) begin fails++; $display("FAIL rd_rsp: timeout=%b done=%b, required 0 1", tmo, done); end
    endtask

    task automatic test_slow_read;
        int n; logic st, tmo, hold, done; logic [31:0] rd;
        do_xfer(1'b1, GONSO_PLUS_ADDR, 32'h0000_00C3, 4'h3, 2, 0, 1'b0, n, st, rd, tmo, hold, done);
        do_xfer(1'b0, GONSO_PLUS_ADDR, 32'h0, 4'h3, 6, 3, 1'b0, n, st, rd, tmo, hold, done);
        checks++; if (n !== 6) begin fails++; $display("FAIL slow_stb_len: got %0d, required 6", n); end
        checks++; if (st !== 1'b1) begin fails++; $display("FAIL slow_bus_stable: got %b, required 1", st); end
        checks++; if (rd !== 32'h0000_00C3) begin fails++; $display("FAIL slow_rdata: got %h, required 000000c3", rd); end
        checks++; if (hold !== 1'b1) begin fails++; $display("FAIL slow_rsp_hold: got %b, required 1", hold); end
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL slow_rsp_done: got %b, required 1", done); end
    endtask

    task automatic test_stray_ack;
        int n; logic st, tmo, hold, done; logic [31:0] rd; logic [31:0] prev;
        do_xfer(1'b1, GONSO_COLOR_ADDR, 32'hA5A5_5A5A, 4'hF, 2, 0, 1'b0, n, st, rd, tmo, hold, done);
        prev = rsp_rdata;
        wbm_ack_i = 1'b1; wbm_dat_i = 32'hFFFF_FFFF;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++; $display("FAIL stray_idle_state: busy=%b valid=%b cyc=%b ready=%b, required 0 0 0 1", busy, rsp_valid, wbm_cyc_o, cmd_ready); end
        checks++; if (rsp_rdata !== prev) begin fails++; $display("FAIL stray_idle_rdata: got %h, required %h", rsp_rdata, prev); end
        do_xfer(1'b0, GONSO_COLOR_ADDR, 32'h0, 4'hF, 2, 2, 1'b1, n, st, rd, tmo, hold, done);
        checks++; if (rd !== 32'hA5A5_5A5A) begin fails++; $display("FAIL stray_rd_rdata: got %h, required a5a55a5a", rd); end
        checks++; if (hold !== 1'b1 || done !== 1'b1) begin fails++; $display("FAIL stray_resp: hold=%b done=%b, required 1 1", hold, done); end
    endtask

`ifdef GONSO_WBM_TIMEOUT_EN
    task automatic test_timeout;
        int n; logic st, tmo, hold, done; logic [31:0] rd;
        do_xfer(1'b0, GONSO_ADDR, 32'h0, 4'hF, 0, 1, 1'b0, n, st, rd, tmo, hold, done);
        checks++; if (n !== 16) begin fails++; $display("FAIL tmo_stb_len: got %0d, required 16", n); end
        checks++; if (tmo !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL tmo_rsp: timeout=%b rdata=%h, required 1 00000000", tmo, rd); end
        checks++; if (hold !== 1'b1 || done !== 1'b1) begin fails++; $display("FAIL tmo_handshake: hold=%b done=%b, required 1 1", hold, done); end
        do_xfer(1'b0, GONSO_ADDR, 32'h0, 4'hF, 16, 0, 1'b0, n, st, rd, tmo, hold, done);
        checks++; if (n !== 16) begin fails++; $display("FAIL tmo_edge_len: got %0d, required 16", n); end
        checks++; if (tmo !== 1'b0 || rd !== 32'h1234_5678) begin fails++; $display("FAIL tmo_edge_rsp: timeout=%b rdata=%h, required 0 12345678", tmo, rd); end
    endtask
`endif

    task automatic test_reset_mid_bus;
        int guard;
        guard = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && guard < 50) begin guard++; @(negedge clk); end
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = GONSO_PLUS_ADDR; cmd_sel = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (wbm_cyc_o !== 1'b1) begin fails++; $display("FAIL midrst_pre_cyc: got %b, required 1", wbm_cyc_o); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
            fails++; $display("FAIL midrst_cyc: cyc=%b stb=%b, required 0 0", wbm_cyc_o, wbm_stb_o); end
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
            fails++; $display("FAIL midrst_ctrl: valid=%b busy=%b ready=%b, required 0 0 0", rsp_valid, busy, cmd_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b, required 1", cmd_ready); end
        repeat (3) @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) begin
            fails++; $display("FAIL midrst_no_rsp: valid=%b cyc=%b, required 0 0", rsp_valid, wbm_cyc_o); end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        cmd_sel = 4'h0; rsp_ready = 1'b0; wbm_dat_i = 32'h0; wbm_ack_i = 1'b0;
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        test_reset();
        test_write();
        test_read();
        test_slow_read();
        test_stray_ack();
`ifdef GONSO_WBM_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_bus();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/gonso_wb_master.md
# gonso_wb_master

Wishbone classic single-transfer initiator for the Gonso user project. It accepts read and write commands on a valid/ready command port and drives them onto the Wishbone bus. It waits for the responder's acknowledge and returns read data and status on a valid/ready response port. It is the bus-side counterpart used to exercise and drive the Gonso register responder (gonso, gonso_plus and gonso_color registers at 0x3003_0004/08/0C) from on-chip logic.

## Interface
- TIMEOUT_CYCLES, 16: maximum cycles a transfer waits for ack; must be ≥2.
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write data
- cmd_sel  in  4  byte enables
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  32  read data; 0 for writes and timeouts
- rsp_timeout  out  1  transfer aborted without ack
- busy  out  1  high whenever state ≠ IDLE
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  strobe, always equal to wbm_cyc_o
- wbm_we_o  out  1  write enable
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_sel_o  out  4  byte enables
- wbm_dat_i  in  32  read data from responder
- wbm_ack_i  in  1  acknowledge from responder

## Operation
States and transitions:
- IDLE: cmd_ready = 1. On handshake, register we/addr/wdata/sel into the wbm_*_o registers, then go to BUS.
- BUS: cyc/stb = 1. Outputs are held stable.
  - On wbm_ack_i: capture wbm_dat_i into rsp_rdata (reads) or 0 (writes), set rsp_timeout = 0, drop cyc/stb, go to RESP.
- RESP: rsp_valid = 1, and rsp_rdata/rsp_timeout are held. On rsp_ready, go to IDLE.

Rules:
- wbm_ack_i outside BUS is ignored.
- cmd_ready is low outside IDLE, so there is never more than one outstanding transfer.
- A new command is not accepted in the same cycle as a response handshake, which gives a one-cycle IDLE bubble between transfers.
- Reset values:
  - cmd_ready = 0 during reset.
  - rsp_valid, rsp_timeout, busy, wbm_cyc_o, wbm_stb_o and wbm_we_o = 0.
  - wbm_adr_o, wbm_dat_o, rsp_rdata = 0x0000_0000; wbm_sel_o = 4'h0.
  - State = IDLE.
- Reset mid-transfer drops cyc/stb at the next edge and discards the command. No response is produced.

## Timing
- Command handshake at edge T → cyc/stb high from T+1.
- With a responder acking in the cycle after stb (the Gonso register block does), ack is sampled at T+2. cyc/stb drop and rsp_valid rises after T+2, and rsp_valid is held until rsp_ready is sampled high.
- If rsp_ready is held high, rsp_valid is high for exactly one cycle. The earliest next command handshake is one cycle after the response handshake.
- All outputs are registered; there is no combinational path from wbm_ack_i to outputs.

## Configuration
- GONSO_WBM_TIMEOUT_EN defined:
  - A counter, cleared on entry to BUS, increments each BUS cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 without ack, cyc/stb drop and the block enters RESP with rsp_timeout = 1 and rsp_rdata = 0.
  - If ack and the terminal count arrive in the same cycle, ack wins (normal response).
- Not defined: no counter. BUS waits indefinitely and rsp_timeout is tied 0.

## Structure
- Shared package gonso_wb_pkg:
  - state enum (IDLE, BUS, RESP);
  - Gonso register address constants 0x3003_0004, 0x3003_0008, 0x3003_000C;
  - Wishbone data/select width constants.
- One sub-module is natural: gonso_wbm_watchdog, the timeout counter.
  - Inputs: clk, rst, clear, count_en. Output: expired.
  - Instantiated only under GONSO_WBM_TIMEOUT_EN.

## Test plan
- Write 0x3003_0004, data 0x1234_5678, sel 4'hF, responder acks 1 cycle after stb → stb high exactly 2 cycles, adr/dat/sel stable throughout, rsp_valid with rdata 0 and timeout 0.
- Read 0x3003_0004 after that write → rsp_rdata = 0x1234_5678.
- Read with ack delayed 5 cycles and rsp_ready low for 3 cycles → cyc/stb held for 6 cycles. rsp_valid and rsp_rdata stay stable until rsp_ready, and cmd_ready stays low until then.
- With GONSO_WBM_TIMEOUT_EN and TIMEOUT_CYCLES = 16, no ack → cyc drops after 16 BUS cycles, rsp_timeout = 1, rsp_rdata = 0. Then ack at exactly the terminal cycle → normal response with timeout = 0.
- Assert rst while in BUS → cyc/stb low at next edge, no rsp_valid, cmd_ready = 1 the cycle after rst deasserts.
- Stray wbm_ack_i pulses in IDLE and RESP → no state change, no response corruption.
